// File: rtl/count_n_if.sv
// Control/status bundle of the count_n counter.
// master drives the controls and observes the count; slave is the counter.
interface count_n_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output enable, up_down, load, load_value, clear,
    input  q, tc, ovf
  );

  modport slave (
    input  enable, up_down, load, load_value, clear,
    output q, tc, ovf
  );
endinterface

// File: rtl/count_n.sv
// Purpose: modulo-N up/down counter with prescaler, load/clear, wrap or saturate.
// Latency: q, tc and ovf are registered, valid one clock after the qualifying edge.
// Backpressure: none; enable gates the prescaler, which gates count steps.
module count_n #(
  parameter int     WIDTH    = 8,
  parameter longint MODULO   = 256,
  parameter int     PRESCALE = 1,
  parameter bit     SATURATE = 1'b0
) (
  input logic      clk,
  input logic      reset,
  count_n_if.slave bus
);

  // A 1-bit prescaler is kept for PRESCALE=1; it then never leaves 0.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic [PW-1:0]    pre_r, pre_nxt;
  logic             tc_r, tc_nxt;
  logic             ovf_r, ovf_nxt;
  logic             step;
  logic             at_end;

  // A step happens on the enabled cycle that completes a prescale period.
  assign step   = bus.enable && (pre_r == PRE_LAST);
  // Range end depends on the direction sampled on the step cycle.
  assign at_end = bus.up_down ? (q_r == MAX) : (q_r == '0);

  // Next-state: clear beats load beats a count step; tc only on an end-of-range step.
  always_comb begin
    q_nxt   = q_r;
    pre_nxt = pre_r;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_r;
    if (bus.clear) begin
      q_nxt   = '0;
      pre_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      // Out-of-range loads clamp to the top of the range so q never leaves 0..MODULO-1.
      q_nxt   = (bus.load_value > MAX) ? MAX : bus.load_value;
      pre_nxt = '0;
    end else if (bus.enable) begin
      if (!step) begin
        pre_nxt = pre_r + PW'(1);
      end else begin
        pre_nxt = '0;
        if (at_end) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (!SATURATE) begin
            q_nxt = bus.up_down ? '0 : MAX;
          end
        end else begin
          q_nxt = bus.up_down ? (q_r + WIDTH'(1)) : (q_r - WIDTH'(1));
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= '0;
      pre_r <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      pre_r <= pre_nxt;
      tc_r  <= tc_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_count_n.sv
// Self-checking bench for count_n: four parameterisations share one clock/reset.
// Each drive pushes the model's prediction to a scoreboard; tests pop and compare.
// Closed-form expectations from the counting rules are checked alongside.
module tb_count_n;

  typedef struct {
    logic [31:0] q;
    logic        tc;
    logic        ovf;
  } out_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  longint mods[4] = '{256, 10, 256, 16};
  int     pres[4] = '{1, 1, 4, 1};
  bit     sats[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  longint mq[4];
  int     mpre[4];
  bit     movf[4];

  always #5 clk = ~clk;

  count_n_if #(.WIDTH(8)) i0();
  count_n_if #(.WIDTH(4)) i1();
  count_n_if #(.WIDTH(8)) i2();
  count_n_if #(.WIDTH(4)) i3();

  count_n d0 (.clk(clk), .reset(reset), .bus(i0));
  count_n #(.WIDTH(4), .MODULO(10)) d1 (.clk(clk), .reset(reset), .bus(i1));
  count_n #(.PRESCALE(4)) d2 (.clk(clk), .reset(reset), .bus(i2));
  count_n #(.WIDTH(4), .MODULO(16), .SATURATE(1'b1)) d3 (.clk(clk), .reset(reset), .bus(i3));

  task automatic set_in(input int id, input bit en, ud, ld, input logic [31:0] lv, input bit clr);
    case (id)
      0: begin i0.enable = en; i0.up_down = ud; i0.load = ld; i0.load_value = lv[7:0]; i0.clear = clr; end
      1: begin i1.enable = en; i1.up_down = ud; i1.load = ld; i1.load_value = lv[3:0]; i1.clear = clr; end
      2: begin i2.enable = en; i2.up_down = ud; i2.load = ld; i2.load_value = lv[7:0]; i2.clear = clr; end
      default: begin i3.enable = en; i3.up_down = ud; i3.load = ld; i3.load_value = lv[3:0]; i3.clear = clr; end
    endcase
  endtask

  function automatic out_t get_out(input int id);
    out_t r;
    case (id)
      0: begin r.q = 32'(i0.q); r.tc = i0.tc; r.ovf = i0.ovf; end
      1: begin r.q = 32'(i1.q); r.tc = i1.tc; r.ovf = i1.ovf; end
      2: begin r.q = 32'(i2.q); r.tc = i2.tc; r.ovf = i2.ovf; end
      default: begin r.q = 32'(i3.q); r.tc = i3.tc; r.ovf = i3.ovf; end
    endcase
    return r;
  endfunction

  // Behavioural reference: range arithmetic in longint, applied in priority order.
  function automatic out_t predict(input int id, input bit en, ud, ld, input logic [31:0] lv, input bit clr);
    out_t r;
    longint m = mods[id];
    r.tc = 1'b0;
    if (clr) begin
      mq[id] = 0; mpre[id] = 0; movf[id] = 1'b0;
    end else if (ld) begin
      mq[id] = (longint'(lv) >= m) ? m - 1 : longint'(lv);
      mpre[id] = 0;
    end else if (en) begin
      if (mpre[id] < pres[id] - 1) begin
        mpre[id]++;
      end else begin
        mpre[id] = 0;
        if (ud && mq[id] == m - 1) begin
          r.tc = 1'b1; movf[id] = 1'b1;
          if (!sats[id]) mq[id] = 0;
        end else if (!ud && mq[id] == 0) begin
          r.tc = 1'b1; movf[id] = 1'b1;
          if (!sats[id]) mq[id] = m - 1;
        end else begin
          mq[id] = ud ? mq[id] + 1 : mq[id] - 1;
        end
      end
    end
    r.q = 32'(mq[id]);
    r.ovf = movf[id];
    return r;
  endfunction

  // One clock on DUT id; other DUTs idle. Prediction goes to the scoreboard.
  task automatic drive(input int id, input bit rst, en, ud, ld, input logic [31:0] lv, input bit clr);
    out_t e;
    for (int k = 0; k < 4; k++) set_in(k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_in(id, en, ud, ld, lv, clr);
    reset = rst;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin mq[k] = 0; mpre[k] = 0; movf[k] = 1'b0; end
      e.q = 32'd0; e.tc = 1'b0; e.ovf = 1'b0;
    end else begin
      e = predict(id, en, ud, ld, lv, clr);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, a;
    for (int c = 0; c < 2; c++) begin
      drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(0); checks++;
      if (a.q !== e.q || a.tc !== e.tc || a.ovf !== e.ovf) begin
        errors++; $display("FAIL reset: q=%0d tc=%b ovf=%b expected q=%0d tc=%b ovf=%b", a.q, a.tc, a.ovf, e.q, e.tc, e.ovf);
      end
    end
    for (int k = 1; k < 4; k++) begin
      a = get_out(k); checks++;
      if (a.q !== 32'd0 || a.tc !== 1'b0 || a.ovf !== 1'b0) begin
        errors++; $display("FAIL reset_dut%0d: q=%0d tc=%b ovf=%b expected 0 0 0", k, a.q, a.tc, a.ovf);
      end
    end
  endtask

  task automatic test_wrap_up();
    out_t e, a;
    for (int k = 1; k <= 258; k++) begin
      drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(0); checks++;
      if (a.q !== e.q || a.tc !== e.tc || a.ovf !== e.ovf) begin
        errors++; $display("FAIL wrap_up step %0d: q=%0d tc=%b ovf=%b expected q=%0d tc=%b ovf=%b", k, a.q, a.tc, a.ovf, e.q, e.tc, e.ovf);
      end
      if (k >= 254) begin
        checks++;
        if (a.q !== 32'(k % 256) || a.tc !== (k == 256) || a.ovf !== (k >= 256)) begin
          errors++; $display("FAIL wrap_up_edge step %0d: q=%0d tc=%b ovf=%b expected q=%0d tc=%b ovf=%b", k, a.q, a.tc, a.ovf, k % 256, k == 256, k >= 256);
        end
      end
    end
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    e = sb.pop_front(); a = get_out(0); checks++;
    if (a.q !== 32'd0 || a.tc !== 1'b0 || a.ovf !== 1'b0 || e.q !== 32'd0) begin
      errors++; $display("FAIL clear: q=%0d tc=%b ovf=%b expected q=0 tc=0 ovf=0", a.q, a.tc, a.ovf);
    end
  endtask

  task automatic test_down_mod10();
    out_t e, a;
    for (int k = 1; k <= 21; k++) begin
      drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(1); checks++;
      if (a.q !== e.q || a.tc !== e.tc || a.ovf !== e.ovf || a.q !== 32'((10 - k % 10) % 10) || a.tc !== (k % 10 == 1)) begin
        errors++; $display("FAIL down_mod10 step %0d: q=%0d tc=%b expected q=%0d tc=%b", k, a.q, a.tc, (10 - k % 10) % 10, k % 10 == 1);
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0);
    e = sb.pop_front(); a = get_out(1); checks++;
    if (a.q !== 32'd9 || a.tc !== 1'b0 || a.q !== e.q) begin
      errors++; $display("FAIL load_clamp: q=%0d tc=%b expected q=9 tc=0", a.q, a.tc);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
    e = sb.pop_front(); a = get_out(1); checks++;
    if (a.q !== 32'd7 || a.q !== e.q) begin
      errors++; $display("FAIL load_in_range: q=%0d expected q=7", a.q);
    end
  endtask

  task automatic test_prescale();
    out_t e, a;
    int n;
    logic [31:0] q0;
    for (int k = 1; k <= 8; k++) begin
      drive(2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(2); checks++;
      if (a.q !== e.q || a.tc !== e.tc || a.q !== 32'(k / 4)) begin
        errors++; $display("FAIL prescale cycle %0d: q=%0d expected q=%0d", k, a.q, k / 4);
      end
    end
    q0 = get_out(2).q;
    n = 0;
    while (get_out(2).q === q0 && n < 20) begin
      n++;
      drive(2, 1'b0, !(n >= 3 && n <= 5), 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(2); checks++;
      if (a.q !== e.q || a.tc !== e.tc) begin
        errors++; $display("FAIL prescale_gap cycle %0d: q=%0d expected q=%0d", n, a.q, e.q);
      end
    end
    checks++;
    if (n != 7) begin
      errors++; $display("FAIL prescale_delay: step after %0d cycles, expected 7", n);
    end
    for (int k = 0; k < 2; k++) begin
      drive(2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      void'(sb.pop_front());
    end
    drive(2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0);
    e = sb.pop_front(); a = get_out(2); checks++;
    if (a.q !== 32'd5 || a.tc !== 1'b0 || a.q !== e.q) begin
      errors++; $display("FAIL prescale_load: q=%0d expected q=5", a.q);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(2); checks++;
      if (a.q !== e.q || a.q !== ((k == 4) ? 32'd6 : 32'd5)) begin
        errors++; $display("FAIL prescale_restart cycle %0d: q=%0d expected q=%0d", k, a.q, (k == 4) ? 6 : 5);
      end
    end
  endtask

  task automatic test_saturate();
    out_t e, a;
    drive(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd14, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 4; k++) begin
      drive(3, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(3); checks++;
      if (a.q !== e.q || a.tc !== e.tc || a.q !== 32'd15 || a.tc !== (k > 1) || a.ovf !== (k > 1)) begin
        errors++; $display("FAIL saturate_up step %0d: q=%0d tc=%b ovf=%b expected q=15 tc=%b ovf=%b", k, a.q, a.tc, a.ovf, k > 1, k > 1);
      end
    end
    drive(3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    e = sb.pop_front(); a = get_out(3); checks++;
    if (a.q !== 32'd15 || a.tc !== 1'b0 || a.tc !== e.tc) begin
      errors++; $display("FAIL tc_idle: q=%0d tc=%b expected q=15 tc=0", a.q, a.tc);
    end
    drive(3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    e = sb.pop_front(); a = get_out(3); checks++;
    if (a.q !== 32'd14 || a.tc !== 1'b0 || a.ovf !== 1'b1 || a.q !== e.q) begin
      errors++; $display("FAIL saturate_down: q=%0d tc=%b ovf=%b expected q=14 tc=0 ovf=1", a.q, a.tc, a.ovf);
    end
  endtask

  task automatic test_load_priority();
    out_t e, a;
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF, 1'b0);
    void'(sb.pop_front());
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
    e = sb.pop_front(); a = get_out(0); checks++;
    if (a.q !== 32'h55 || a.tc !== 1'b0 || a.ovf !== 1'b0 || a.q !== e.q) begin
      errors++; $display("FAIL load_over_step: q=%0h tc=%b ovf=%b expected q=55 tc=0 ovf=0", a.q, a.tc, a.ovf);
    end
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1);
    e = sb.pop_front(); a = get_out(0); checks++;
    if (a.q !== 32'd0 || a.tc !== 1'b0 || a.q !== e.q) begin
      errors++; $display("FAIL clear_over_load: q=%0h tc=%b expected q=0 tc=0", a.q, a.tc);
    end
  endtask

  task automatic test_reset_mid();
    out_t e, a;
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF, 1'b0);
    void'(sb.pop_front());
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    void'(sb.pop_front());
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    e = sb.pop_front(); a = get_out(0); checks++;
    if (a.q !== 32'h80 || a.ovf !== 1'b1 || a.ovf !== e.ovf) begin
      errors++; $display("FAIL load_keeps_ovf: q=%0h ovf=%b expected q=80 ovf=1", a.q, a.ovf);
    end
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    e = sb.pop_front(); a = get_out(0); checks++;
    if (a.q !== 32'd0 || a.tc !== 1'b0 || a.ovf !== 1'b0 || a.q !== e.q) begin
      errors++; $display("FAIL reset_mid: q=%0h tc=%b ovf=%b expected 0 0 0", a.q, a.tc, a.ovf);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      e = sb.pop_front(); a = get_out(0); checks++;
      if (a.q !== e.q || a.q !== 32'(k) || a.tc !== 1'b0) begin
        errors++; $display("FAIL resume step %0d: q=%0d expected q=%0d", k, a.q, k);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) set_in(k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    test_reset();
    test_wrap_up();
    test_down_mod10();
    test_prescale();
    test_saturate();
    test_load_priority();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_n.md
Name: count_n

Overview:
- Parametrised successor to the 8-bit enable-gated counter.
- Adds configurable width and modulo, up/down direction, synchronous load and clear, an enable prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as the general timebase/event counter in lab designs; drives displays, timers and FSM timeouts.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MODULO, 256, count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2^WIDTH.
- PRESCALE, 1, number of enabled cycles per count step (1 = step on every enabled cycle).
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, count enable; qualifies prescaler advance.
- up_down, input, 1, 1 = count up, 0 = count down; sampled on the step cycle.
- load, input, 1, synchronous load of load_value.
- load_value, input, WIDTH, value to load.
- clear, input, 1, synchronous clear of q, prescaler and ovf.
- q, output, WIDTH, registered count value.
- tc, output, 1, registered one-cycle terminal-count pulse.
- ovf, output, 1, sticky flag; set with tc.

Behaviour:
- Reset value: q=0, tc=0, ovf=0, prescaler=0.
- All state updates on the rising edge of clk.
- Priority per cycle: reset > clear > load > count step.
- clear: q=0, prescaler=0, ovf=0, tc=0.
- load: q=load_value if load_value<MODULO, otherwise q=MODULO-1 (clamp). Prescaler resets to 0, tc=0, ovf unchanged. Load takes effect regardless of enable.
- Prescaler: internal counter pre, 0..PRESCALE-1.
  - If enable=1 and pre<PRESCALE-1: pre increments and there is no step.
  - If enable=1 and pre=PRESCALE-1: pre returns to 0 and a step occurs.
  - If enable=0: pre and q hold.
  - PRESCALE=1 means every enabled cycle is a step; pre is then constant 0.
- Step, up, wrap mode (SATURATE=0):
  - q<MODULO-1: q+1.
  - q=MODULO-1: q=0, tc=1, ovf=1.
- Step, down, wrap mode:
  - q>0: q-1.
  - q=0: q=MODULO-1, tc=1, ovf=1.
- Step, saturate mode (SATURATE=1): at a range end (MODULO-1 going up, 0 going down), q holds, tc=1 and ovf=1 on every such step attempt.
- tc: 1 only in the cycle after the qualifying step edge, coincident with the new q. Otherwise 0, including while enable=0.
- Arithmetic is modulo MODULO, never 2^WIDTH. A non-power-of-2 MODULO must not pass through values >= MODULO.
- Direction change mid-count takes effect on the next step; the prescaler is unaffected.
- enable dropping mid-prescale freezes pre; counting resumes from the same pre value.
- Simultaneous load and step: load wins and tc=0.
- Simultaneous clear and load: clear wins, q=0.
- Reset mid-count: next cycle all outputs are at their reset values.
- Latency: q, tc and ovf are valid one clock after the qualifying edge. There are no combinational paths from inputs to outputs.

Test Plan:
1. Defaults, reset 2 cycles, enable=1, up → q goes 0,1,...,255,0. tc=1 only in the cycle q=0 after 255, ovf=1 from then on. Raise clear → q=0, ovf=0.
2. WIDTH=4, MODULO=10, up_down=0 from q=0 → q goes 9,8,...,0,9 with tc pulsed at each 0→9. load_value=12 → q=9 (clamp).
3. PRESCALE=4, enable=1 → q increments every 4th cycle. Toggle enable low for 3 cycles mid-prescale → step is delayed by exactly 3 cycles.
4. SATURATE=1, MODULO=16, up from 14 → q goes 15,15,15 with tc=1 on each held step. Switch to down → 14, tc=0.
5. Load 0x55 while enable=1 and at a step boundary → q=0x55 next cycle, tc=0, prescaler restarts. Same cycle with clear=1 → q=0.
6. Assert reset while q=0x80 and ovf=1 → next cycle q=0, tc=0, ovf=0. Counting resumes 0,1,... after reset drops.
